// File: rtl/hp2vga_pkg.sv
// Shared types for the line bank scheduler.
// Holds the FSM state encoding and the default bank-address width.
package hp2vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } sched_state_e;

  localparam int DEF_BANK_BITS = 2;

endpackage

// File: rtl/toggle_sync.sv
// Brings an async toggle into clk_i: 2-FF sync plus one history flop.
// Ports: clk_i, rst_ni, tog_i (async toggle), ev_o (one-cycle event).
module toggle_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tog_i,
  output logic ev_o
);

  logic ff1_q, ff2_q, ff3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
      ff3_q <= 1'b0;
    end else begin
      ff1_q <= tog_i;
      ff2_q <= ff1_q;
      ff3_q <= ff2_q;
    end
  end

  assign ev_o = ff2_q ^ ff3_q;

endmodule

// File: rtl/line_bank_scheduler.sv
// Bank pointers, fill level, prime/run FSM and error counters for a
// multi-bank line buffer. In: CLK, RESET_N, RX_LINE_TOG, RX_FRAME_TOG,
// TX_LINE_REQ. Out: WR_BANK, RD_BANK, FILL, STATE, RESYNC, LOCKED,
// OVERFLOW_CNT, UNDERFLOW_CNT.
module line_bank_scheduler
  import hp2vga_pkg::*;
#(
  parameter int BANK_BITS   = DEF_BANK_BITS,
  parameter int PRIME_LINES = 1,
  parameter int LOCK_LINES  = 16,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 RX_LINE_TOG,
  input  logic                 RX_FRAME_TOG,
  input  logic                 TX_LINE_REQ,
  output logic [BANK_BITS-1:0] WR_BANK,
  output logic [BANK_BITS-1:0] RD_BANK,
  output logic [BANK_BITS-1:0] FILL,
  output logic [1:0]           STATE,
  output logic                 RESYNC,
  output logic                 LOCKED,
  output logic [CNT_WIDTH-1:0] OVERFLOW_CNT,
  output logic [CNT_WIDTH-1:0] UNDERFLOW_CNT
);

  localparam int DEPTH = 2 ** BANK_BITS;
  localparam int CW    = $clog2(LOCK_LINES + 1);

  localparam logic [BANK_BITS-1:0] ONE  = BANK_BITS'(1);
  localparam logic [BANK_BITS-1:0] FULL = BANK_BITS'(DEPTH - 2);
  localparam logic [BANK_BITS-1:0] PRM  = BANK_BITS'(PRIME_LINES);
  localparam logic [CW-1:0]        LCK  = CW'(LOCK_LINES);
  localparam logic [CW-1:0]        C1   = CW'(1);
  localparam logic [CNT_WIDTH-1:0] E1   = CNT_WIDTH'(1);

  sched_state_e state_q, state_d;
  logic [BANK_BITS-1:0] wr_q, wr_d;
  logic [BANK_BITS-1:0] rd_q, rd_d;
  logic [BANK_BITS-1:0] fill_q, fill_d;
  logic                 resync_q, resync_d;
  logic                 locked_q, locked_d;
  logic [CW-1:0]        clean_q, clean_d;
  logic [CNT_WIDTH-1:0] ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] unf_q, unf_d;

  logic line_ev, frame_ev;
  logic active, rd_ok, rd_unf, cm_ok, cm_ovf;

  toggle_sync u_line_sync (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .tog_i  (RX_LINE_TOG),
    .ev_o   (line_ev)
  );

  toggle_sync u_frame_sync (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .tog_i  (RX_FRAME_TOG),
    .ev_o   (frame_ev)
  );

  // Read success uses registered FILL only; a commit can rescue a
  // full buffer by riding on a read, but never the reverse.
  assign active = (state_q != ST_IDLE);
  assign rd_ok  = (state_q == ST_RUN) && TX_LINE_REQ && (fill_q != '0);
  assign rd_unf = (state_q == ST_RUN) && TX_LINE_REQ && (fill_q == '0);
  assign cm_ok  = active && line_ev && ((fill_q < FULL) || rd_ok);
  assign cm_ovf = active && line_ev && !cm_ok;

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    fill_d   = fill_q;
    resync_d = 1'b0;
    locked_d = locked_q;
    clean_d  = clean_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (cm_ok)
      wr_d = wr_q + ONE;
    if (rd_ok)
      rd_d = rd_q + ONE;
    if (cm_ok && !rd_ok)
      fill_d = fill_q + ONE;
    else if (rd_ok && !cm_ok)
      fill_d = fill_q - ONE;

    if (rd_ok && (clean_q != LCK))
      clean_d = clean_q + C1;
    if (rd_ok && (clean_d == LCK))
      locked_d = 1'b1;

    if (cm_ovf && (ovf_q != '1))
      ovf_d = ovf_q + E1;
    if (rd_unf && (unf_q != '1))
      unf_d = unf_q + E1;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_ev) begin
          wr_d    = ONE;
          rd_d    = '0;
          fill_d  = '0;
          state_d = ST_PRIME;
        end
      end
      ST_PRIME: begin
        if (fill_q >= PRM) begin
          state_d  = ST_RUN;
          resync_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (cm_ovf || rd_unf) begin
          state_d  = ST_PRIME;
          locked_d = 1'b0;
          clean_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      wr_q     <= ONE;
      rd_q     <= '0;
      fill_q   <= '0;
      resync_q <= 1'b0;
      locked_q <= 1'b0;
      clean_q  <= '0;
      ovf_q    <= '0;
      unf_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      fill_q   <= fill_d;
      resync_q <= resync_d;
      locked_q <= locked_d;
      clean_q  <= clean_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign WR_BANK       = wr_q;
  assign RD_BANK       = rd_q;
  assign FILL          = fill_q;
  assign STATE         = state_q;
  assign RESYNC        = resync_q;
  assign LOCKED        = locked_q;
  assign OVERFLOW_CNT  = ovf_q;
  assign UNDERFLOW_CNT = unf_q;

endmodule

// File: tb/tb_line_bank_scheduler.sv
// Directed bench for line_bank_scheduler (default parameters).
// Inputs change 1 time unit after a rising edge; outputs sampled there.
module tb_line_bank_scheduler;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       RX_LINE_TOG = 1'b0;
  logic       RX_FRAME_TOG = 1'b0;
  logic       TX_LINE_REQ = 1'b0;
  logic [1:0] WR_BANK, RD_BANK, FILL, STATE;
  logic       RESYNC, LOCKED;
  logic [7:0] OVERFLOW_CNT, UNDERFLOW_CNT;

  int n_chk = 0;
  int n_fail = 0;

  line_bank_scheduler dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .RX_LINE_TOG   (RX_LINE_TOG),
    .RX_FRAME_TOG  (RX_FRAME_TOG),
    .TX_LINE_REQ   (TX_LINE_REQ),
    .WR_BANK       (WR_BANK),
    .RD_BANK       (RD_BANK),
    .FILL          (FILL),
    .STATE         (STATE),
    .RESYNC        (RESYNC),
    .LOCKED        (LOCKED),
    .OVERFLOW_CNT  (OVERFLOW_CNT),
    .UNDERFLOW_CNT (UNDERFLOW_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // toggle sampled at the next edge, takes effect two edges later
  task automatic commit_line();
    RX_LINE_TOG = ~RX_LINE_TOG;
    tick(3);
  endtask

  task automatic read_line();
    TX_LINE_REQ = 1'b1;
    tick(1);
    TX_LINE_REQ = 1'b0;
  endtask

  // line event and read request land on the same edge
  task automatic commit_and_read();
    RX_LINE_TOG = ~RX_LINE_TOG;
    tick(2);
    TX_LINE_REQ = 1'b1;
    tick(1);
    TX_LINE_REQ = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    tick(2);
    n_chk++; if (STATE !== 2'd0) begin n_fail++; $display("FAIL rst_state got %0d want 0", STATE); end
    n_chk++; if (WR_BANK !== 2'd1) begin n_fail++; $display("FAIL rst_wr got %0d want 1", WR_BANK); end
    n_chk++; if (RD_BANK !== 2'd0) begin n_fail++; $display("FAIL rst_rd got %0d want 0", RD_BANK); end
    n_chk++; if (FILL !== 2'd0) begin n_fail++; $display("FAIL rst_fill got %0d want 0", FILL); end
    n_chk++; if ({RESYNC, LOCKED} !== 2'b00) begin n_fail++; $display("FAIL rst_flags got %b want 00", {RESYNC, LOCKED}); end
    n_chk++; if ({OVERFLOW_CNT, UNDERFLOW_CNT} !== 16'd0) begin n_fail++; $display("FAIL rst_cnts got %h want 0", {OVERFLOW_CNT, UNDERFLOW_CNT}); end
    RESET_N = 1'b1;
    tick(1);
    commit_line();
    read_line();
    tick(1);
    n_chk++; if (STATE !== 2'd0) begin n_fail++; $display("FAIL idle_state got %0d want 0", STATE); end
    n_chk++; if ({WR_BANK, FILL} !== 4'b0100) begin n_fail++; $display("FAIL idle_ptrs got %b want 0100", {WR_BANK, FILL}); end
    n_chk++; if (UNDERFLOW_CNT !== 8'd0) begin n_fail++; $display("FAIL idle_unf got %0d want 0", UNDERFLOW_CNT); end
  endtask

  task automatic test_frame_start();
    RX_FRAME_TOG = ~RX_FRAME_TOG;
    tick(2);
    n_chk++; if (STATE !== 2'd0) begin n_fail++; $display("FAIL frame_early got %0d want 0", STATE); end
    tick(1);
    n_chk++; if (STATE !== 2'd1) begin n_fail++; $display("FAIL frame_state got %0d want 1", STATE); end
    n_chk++; if ({WR_BANK, RD_BANK, FILL} !== 6'b01_00_00) begin n_fail++; $display("FAIL frame_ptrs got %b want 010000", {WR_BANK, RD_BANK, FILL}); end
  endtask

  task automatic test_prime();
    read_line();
    n_chk++; if ({RD_BANK, UNDERFLOW_CNT} !== 10'd0) begin n_fail++; $display("FAIL prime_read got %h want 0", {RD_BANK, UNDERFLOW_CNT}); end
    commit_line();
    n_chk++; if ({FILL, WR_BANK, STATE} !== 6'b01_10_01) begin n_fail++; $display("FAIL prime_commit got %b want 011001", {FILL, WR_BANK, STATE}); end
    n_chk++; if (RESYNC !== 1'b0) begin n_fail++; $display("FAIL prime_resync0 got %b want 0", RESYNC); end
    tick(1);
    n_chk++; if ({STATE, RESYNC} !== 3'b10_1) begin n_fail++; $display("FAIL run_entry got %b want 101", {STATE, RESYNC}); end
    tick(1);
    n_chk++; if ({STATE, RESYNC} !== 3'b10_0) begin n_fail++; $display("FAIL resync_pulse got %b want 100", {STATE, RESYNC}); end
  endtask

  task automatic test_lock();
    for (int i = 1; i <= 20; i++) begin
      read_line();
      n_chk++; if (LOCKED !== (i >= 16)) begin n_fail++; $display("FAIL lock_read%0d got %b want %b", i, LOCKED, (i >= 16)); end
      n_chk++; if ({FILL, RD_BANK} !== {2'd0, 2'(i)}) begin n_fail++; $display("FAIL lock_rd%0d got %b want %b", i, {FILL, RD_BANK}, {2'd0, 2'(i)}); end
      commit_line();
      n_chk++; if (FILL !== 2'd1) begin n_fail++; $display("FAIL lock_fill%0d got %0d want 1", i, FILL); end
    end
    n_chk++; if ({STATE, WR_BANK, RD_BANK} !== 6'b10_10_00) begin n_fail++; $display("FAIL lock_end got %b want 101000", {STATE, WR_BANK, RD_BANK}); end
    n_chk++; if ({OVERFLOW_CNT, UNDERFLOW_CNT} !== 16'd0) begin n_fail++; $display("FAIL lock_cnts got %h want 0", {OVERFLOW_CNT, UNDERFLOW_CNT}); end
  endtask

  task automatic test_underflow();
    read_line();
    n_chk++; if ({FILL, RD_BANK, LOCKED} !== 5'b00_01_1) begin n_fail++; $display("FAIL unf_pre got %b want 00011", {FILL, RD_BANK, LOCKED}); end
    read_line();
    n_chk++; if (RD_BANK !== 2'd1) begin n_fail++; $display("FAIL unf_rd got %0d want 1", RD_BANK); end
    n_chk++; if (UNDERFLOW_CNT !== 8'd1) begin n_fail++; $display("FAIL unf_cnt got %0d want 1", UNDERFLOW_CNT); end
    n_chk++; if ({LOCKED, STATE} !== 3'b0_01) begin n_fail++; $display("FAIL unf_state got %b want 001", {LOCKED, STATE}); end
  endtask

  task automatic test_overflow();
    commit_line();
    n_chk++; if ({FILL, WR_BANK, STATE} !== 6'b01_11_01) begin n_fail++; $display("FAIL ovf_c1 got %b want 011101", {FILL, WR_BANK, STATE}); end
    commit_line();
    n_chk++; if ({FILL, WR_BANK, STATE} !== 6'b10_00_10) begin n_fail++; $display("FAIL ovf_c2 got %b want 100010", {FILL, WR_BANK, STATE}); end
    commit_line();
    n_chk++; if ({FILL, WR_BANK} !== 4'b10_00) begin n_fail++; $display("FAIL ovf_c3 got %b want 1000", {FILL, WR_BANK}); end
    n_chk++; if ({OVERFLOW_CNT, STATE} !== {8'd1, 2'd1}) begin n_fail++; $display("FAIL ovf_cnt got %h want 0x5", {OVERFLOW_CNT, STATE}); end
    tick(1);
    n_chk++; if ({STATE, RESYNC, RD_BANK} !== 5'b10_1_01) begin n_fail++; $display("FAIL ovf_rerun got %b want 10101", {STATE, RESYNC, RD_BANK}); end
  endtask

  task automatic test_back_to_back();
    read_line();
    n_chk++; if ({FILL, RD_BANK} !== 4'b01_10) begin n_fail++; $display("FAIL b2b_pre got %b want 0110", {FILL, RD_BANK}); end
    commit_and_read();
    n_chk++; if ({FILL, RD_BANK, WR_BANK} !== 6'b01_11_01) begin n_fail++; $display("FAIL b2b got %b want 011101", {FILL, RD_BANK, WR_BANK}); end
    n_chk++; if ({STATE, OVERFLOW_CNT, UNDERFLOW_CNT} !== {2'd2, 8'd1, 8'd1}) begin n_fail++; $display("FAIL b2b_cnts got %h want 20101", {STATE, OVERFLOW_CNT, UNDERFLOW_CNT}); end
    read_line();
    commit_and_read();
    n_chk++; if ({FILL, RD_BANK, WR_BANK} !== 6'b01_00_10) begin n_fail++; $display("FAIL b2b_zero got %b want 010010", {FILL, RD_BANK, WR_BANK}); end
    n_chk++; if ({STATE, UNDERFLOW_CNT} !== {2'd1, 8'd2}) begin n_fail++; $display("FAIL b2b_zero_unf got %h want 102", {STATE, UNDERFLOW_CNT}); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 298; i++) begin
      tick(1);
      read_line();
      commit_and_read();
    end
    n_chk++; if (UNDERFLOW_CNT !== 8'd255) begin n_fail++; $display("FAIL unf_sat got %0d want 255", UNDERFLOW_CNT); end
    n_chk++; if (OVERFLOW_CNT !== 8'd1) begin n_fail++; $display("FAIL sat_ovf got %0d want 1", OVERFLOW_CNT); end
  endtask

  task automatic test_async_reset();
    tick(1);
    n_chk++; if (STATE !== 2'd2) begin n_fail++; $display("FAIL ar_pre got %0d want 2", STATE); end
    #2 RESET_N = 1'b0;
    #1;
    n_chk++; if ({STATE, WR_BANK, RD_BANK, FILL} !== 8'b00_01_00_00) begin n_fail++; $display("FAIL ar_ptrs got %b want 00010000", {STATE, WR_BANK, RD_BANK, FILL}); end
    n_chk++; if ({RESYNC, LOCKED, OVERFLOW_CNT, UNDERFLOW_CNT} !== 18'd0) begin n_fail++; $display("FAIL ar_rest got %h want 0", {RESYNC, LOCKED, OVERFLOW_CNT, UNDERFLOW_CNT}); end
    tick(1);
    RESET_N = 1'b1;
  endtask

  initial begin
    test_reset();
    test_frame_start();
    test_prime();
    test_lock();
    test_underflow();
    test_overflow();
    test_back_to_back();
    test_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
